// File: rtl/led_pkg.sv
// Shared definitions for the LED bar sequencer: mode encoding, default bar
// width and index-width helper.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_SCAN  = 2'd0,
        MODE_FILL  = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_OFF   = 2'd3
    } mode_t;

    localparam int LED_NUM_DEFAULT = 6;

    function automatic int led_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic mode_t mode_succ(input mode_t m);
        case (m)
            MODE_SCAN:  return MODE_FILL;
            MODE_FILL:  return MODE_BLINK;
            MODE_BLINK: return MODE_OFF;
            default:    return MODE_SCAN;
        endcase
    endfunction

endpackage

// File: rtl/step_prescaler.sv
// Step-rate prescaler: counts to (div_base >> speed) - 1 while enabled and
// emits a single-cycle fire strobe on wrap; clear forces the count to 0.
module step_prescaler #(
    parameter int DIV_WIDTH = 24,
    parameter int DIV_BASE  = 2700000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       enable,
    input  logic       clear,
    input  logic [1:0] speed,
    output logic       fire
);

    localparam logic [DIV_WIDTH-1:0] BASE = DIV_WIDTH'(DIV_BASE);
    localparam logic [DIV_WIDTH-1:0] ONE  = DIV_WIDTH'(1);

    logic [DIV_WIDTH-1:0] count;
    logic [DIV_WIDTH-1:0] terminal;
    logic                 wrap;

    assign terminal = (BASE >> speed) - ONE;
    // >= rather than == so a speed increase that lowers the terminal below
    // the current count wraps on the next cycle instead of overrunning.
    assign wrap     = (count >= terminal);
    assign fire     = enable && !clear && wrap;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= wrap ? '0 : count + ONE;
        end
    end

endmodule

// File: rtl/led_mode_sequencer.sv
// Four-mode pattern sequencer for the active-low LED bar (scan/fill/blink/off).
// Optional SCAN_TRAIL_EN adds a dim 25%-duty trail LED behind the scanner.
module led_mode_sequencer
    import led_pkg::*;
#(
    parameter int NUM_LEDS  = LED_NUM_DEFAULT,
    parameter int DIV_WIDTH = 24,
    parameter int DIV_BASE  = 2700000
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                mode_next,
    input  logic                run,
    input  logic [1:0]          speed,
    output logic [NUM_LEDS-1:0] led,
    output logic [1:0]          mode,
    output logic                step
);

    localparam int IDX_W  = led_idx_w(NUM_LEDS);
    localparam int FILL_W = $clog2(NUM_LEDS + 1);

    localparam logic [IDX_W-1:0]    IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(NUM_LEDS - 1);
    localparam logic [FILL_W-1:0]   FILL_ONE = FILL_W'(1);
    localparam logic [FILL_W-1:0]   FILL_MAX = FILL_W'(NUM_LEDS);
    localparam logic [NUM_LEDS-1:0] ONE_LED  = NUM_LEDS'(1);
    localparam logic [NUM_LEDS-1:0] ALL_ON   = {NUM_LEDS{1'b1}};

    mode_t               mode_q,     nxt_mode;
    logic [IDX_W-1:0]    index_q,    nxt_index;
    logic                dir_up_q,   nxt_dir_up;
    logic [FILL_W-1:0]   fill_q,     nxt_fill;
    logic                blink_on_q, nxt_blink_on;
    logic [NUM_LEDS-1:0] led_q,      nxt_led;
    logic [NUM_LEDS-1:0] scan_bits;
    logic                step_q;
    logic                fire;

    step_prescaler #(
        .DIV_WIDTH (DIV_WIDTH),
        .DIV_BASE  (DIV_BASE)
    ) u_prescaler (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .enable  (run && (mode_q != MODE_OFF)),
        .clear   (mode_next),
        .speed   (speed),
        .fire    (fire)
    );

    // mode_next has priority; the prescaler suppresses fire on that cycle.
    always_comb begin
        nxt_mode     = mode_q;
        nxt_index    = index_q;
        nxt_dir_up   = dir_up_q;
        nxt_fill     = fill_q;
        nxt_blink_on = blink_on_q;
        if (mode_next) begin
            nxt_mode     = mode_succ(mode_q);
            nxt_index    = '0;
            nxt_dir_up   = 1'b1;
            nxt_fill     = '0;
            nxt_blink_on = 1'b1;
        end else if (fire) begin
            case (mode_q)
                MODE_SCAN: begin
                    if (dir_up_q) begin
                        nxt_index = index_q + IDX_ONE;
                        if (nxt_index == IDX_LAST) nxt_dir_up = 1'b0;
                    end else begin
                        nxt_index = index_q - IDX_ONE;
                        if (nxt_index == '0) nxt_dir_up = 1'b1;
                    end
                end
                MODE_FILL:  nxt_fill     = (fill_q == FILL_MAX) ? '0 : fill_q + FILL_ONE;
                MODE_BLINK: nxt_blink_on = !blink_on_q;
                default: ;
            endcase
        end
    end

`ifdef SCAN_TRAIL_EN
    logic [1:0]       pwm_q;
    logic [IDX_W-1:0] prev_q,  nxt_prev;
    logic             trail_q, nxt_trail;

    always_comb begin
        nxt_prev  = prev_q;
        nxt_trail = trail_q;
        if (mode_next) begin
            nxt_prev  = '0;
            nxt_trail = 1'b0;
        end else if (fire && (mode_q == MODE_SCAN)) begin
            nxt_prev  = index_q;
            nxt_trail = (index_q != nxt_index);
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            pwm_q   <= 2'd0;
            prev_q  <= '0;
            trail_q <= 1'b0;
        end else begin
            pwm_q   <= pwm_q + 2'd1;
            prev_q  <= nxt_prev;
            trail_q <= nxt_trail;
        end
    end

    // led is registered, so light the trail on the edge that brings pwm to 0.
    always_comb begin
        scan_bits = ONE_LED << nxt_index;
        if (nxt_trail && (pwm_q == 2'd3)) scan_bits = scan_bits | (ONE_LED << nxt_prev);
    end
`else
    always_comb begin
        scan_bits = ONE_LED << nxt_index;
    end
`endif

    always_comb begin
        nxt_led = ALL_ON;
        case (nxt_mode)
            MODE_SCAN:  nxt_led = ~scan_bits;
            MODE_FILL:  nxt_led = ALL_ON << nxt_fill;
            MODE_BLINK: nxt_led = nxt_blink_on ? '0 : ALL_ON;
            default:    nxt_led = ALL_ON;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            mode_q     <= MODE_SCAN;
            index_q    <= '0;
            dir_up_q   <= 1'b1;
            fill_q     <= '0;
            blink_on_q <= 1'b1;
            led_q      <= ~ONE_LED;
            step_q     <= 1'b0;
        end else begin
            mode_q     <= nxt_mode;
            index_q    <= nxt_index;
            dir_up_q   <= nxt_dir_up;
            fill_q     <= nxt_fill;
            blink_on_q <= nxt_blink_on;
            led_q      <= nxt_led;
            step_q     <= fire;
        end
    end

    assign led  = led_q;
    assign mode = mode_q;
    assign step = step_q;

endmodule
